// File: rtl/sdram_host_frontend.sv
// Host-side request front-end for the single-port SDRAM controller: buffers host
// requests in a small FIFO, issues them one at a time, and returns read data.
module sdram_host_frontend #(
  parameter int HADDR_WIDTH    = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_AW        = 2,
  parameter int ACCEPT_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic [HADDR_WIDTH-1:0] ctl_wr_addr,
  output logic [DATA_WIDTH-1:0]  ctl_wr_data,
  output logic                   ctl_wr_enable,
  output logic [HADDR_WIDTH-1:0] ctl_rd_addr,
  output logic                   ctl_rd_enable,
  input  logic [DATA_WIDTH-1:0]  ctl_rd_data,
  input  logic                   ctl_rd_ready,
  input  logic                   ctl_busy,
  output logic [FIFO_AW:0]       fifo_level,
  output logic                   timeout_err,
  output logic                   idle
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int EW    = 1 + HADDR_WIDTH + DATA_WIDTH;
  localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [8:0]       TMO_LIMIT  = {1'b0, 8'(ACCEPT_TIMEOUT)};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN} state_t;

  state_t                 state, state_next;
  logic [EW-1:0]          fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
  logic [FIFO_AW:0]       level;
  logic                   push, pop;
  logic [EW-1:0]          head;
  logic                   head_we;
  logic                   cur_we;
  logic [HADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]  cur_wdata;
  logic [7:0]             wait_cnt;
  logic [8:0]             wait_cnt_inc;
  logic                   rd_seen;

  assign req_ready    = (level != FULL_LEVEL);
  assign push         = req_valid & req_ready;
  assign head         = fifo_mem[rd_ptr];
  assign head_we      = head[EW-1];
  // A read may not leave the FIFO while the response slot is still occupied.
  assign pop          = (state == S_IDLE) && (level != '0) && (head_we || !rsp_valid);
  assign wait_cnt_inc = {1'b0, wait_cnt} + 9'd1;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_we, req_addr, req_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pop) state_next = S_ISSUE;
      S_ISSUE: if (ctl_busy) state_next = S_RUN;
      S_RUN:   if (!ctl_busy && (cur_we || rd_seen)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ctl_wr_enable = 1'b0;
    ctl_rd_enable = 1'b0;
    if (state == S_ISSUE) begin
      ctl_wr_enable = cur_we;
      ctl_rd_enable = ~cur_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_we      <= 1'b0;
      cur_addr    <= '0;
      cur_wdata   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      rd_seen     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      if (pop) begin
        {cur_we, cur_addr, cur_wdata} <= head;
        wait_cnt <= '0;
        rd_seen  <= 1'b0;
      end else if (state == S_ISSUE) begin
        if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt_inc[7:0];
        if (wait_cnt_inc >= TMO_LIMIT) timeout_err <= 1'b1;
      end
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (state == S_RUN && !cur_we && ctl_rd_ready) begin
        rsp_rdata <= ctl_rd_data;
        rsp_valid <= 1'b1;
        rd_seen   <= 1'b1;
      end
    end
  end

  assign ctl_wr_addr = cur_addr;
  assign ctl_rd_addr = cur_addr;
  assign ctl_wr_data = cur_wdata;
  assign fifo_level  = level;
  assign idle        = (state == S_IDLE) && (level == '0);

endmodule
